// File: rtl/addsub_arbiter_if.sv
// Handshake bundle for the two-requester add/subtract arbiter.
// The slave side is the arbiter; the master side is the issue logic and the result consumer.
interface addsub_arbiter_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [DATA_W-1:0] req0_a_i;
    logic [DATA_W-1:0] req0_b_i;
    logic              req0_sel_i;

    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [DATA_W-1:0] req1_a_i;
    logic [DATA_W-1:0] req1_b_i;
    logic              req1_sel_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_s_o;
    logic              rsp_c_o;
    logic              rsp_id_o;

    logic [CNT_W-1:0]  gnt_cnt0_o;
    logic [CNT_W-1:0]  gnt_cnt1_o;

    modport slave (
        input  req0_valid_i, req0_a_i, req0_b_i, req0_sel_i,
        input  req1_valid_i, req1_a_i, req1_b_i, req1_sel_i,
        input  rsp_ready_i,
        output req0_ready_o, req1_ready_o,
        output rsp_valid_o, rsp_s_o, rsp_c_o, rsp_id_o,
        output gnt_cnt0_o, gnt_cnt1_o
    );

    modport master (
        output req0_valid_i, req0_a_i, req0_b_i, req0_sel_i,
        output req1_valid_i, req1_a_i, req1_b_i, req1_sel_i,
        output rsp_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp_valid_o, rsp_s_o, rsp_c_o, rsp_id_o,
        input  gnt_cnt0_o, gnt_cnt1_o
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/subtract datapath between two requesters,
// with a single-entry registered response slot and saturating per-requester grant counters.
module addsub_arbiter #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    addsub_arbiter_if.slave    bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rsp_s_q, rsp_s_d;
    logic              rsp_c_q, rsp_c_d;
    logic              rsp_id_q, rsp_id_d;
    logic              last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]  gnt_cnt0_q, gnt_cnt0_d;
    logic [CNT_W-1:0]  gnt_cnt1_q, gnt_cnt1_d;

    logic              accept_ok;
    logic              cand;
    logic              ready0;
    logic              ready1;
    logic              fire;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_sel;
    logic [DATA_W:0]   result;

    // Ready is held low during reset so a requester never sees a handshake that is not taken.
    always_comb begin
        accept_ok = rst_ni && ((state_q == EMPTY) || bus.rsp_ready_i);
        if (bus.req0_valid_i && bus.req1_valid_i) begin
            cand = ~last_gnt_q;
        end else begin
            cand = bus.req1_valid_i;
        end
        ready0 = accept_ok && bus.req0_valid_i && !cand;
        ready1 = accept_ok && bus.req1_valid_i &&  cand;
        fire   = ready0 || ready1;
    end

    always_comb begin
        op_a   = cand ? bus.req1_a_i   : bus.req0_a_i;
        op_b   = cand ? bus.req1_b_i   : bus.req0_b_i;
        op_sel = cand ? bus.req1_sel_i : bus.req0_sel_i;
        if (op_sel) begin
            result = {1'b0, op_a} - {1'b0, op_b};
        end else begin
            result = {1'b0, op_a} + {1'b0, op_b};
        end
    end

    always_comb begin
        state_d    = state_q;
        rsp_s_d    = rsp_s_q;
        rsp_c_d    = rsp_c_q;
        rsp_id_d   = rsp_id_q;
        last_gnt_d = last_gnt_q;
        gnt_cnt0_d = gnt_cnt0_q;
        gnt_cnt1_d = gnt_cnt1_q;
        if (fire) begin
            state_d    = FULL;
            rsp_s_d    = result[DATA_W-1:0];
            rsp_c_d    = result[DATA_W];
            rsp_id_d   = cand;
            last_gnt_d = cand;
            if (!cand && (gnt_cnt0_q != {CNT_W{1'b1}})) begin
                gnt_cnt0_d = gnt_cnt0_q + CNT_W'(1);
            end
            if (cand && (gnt_cnt1_q != {CNT_W{1'b1}})) begin
                gnt_cnt1_d = gnt_cnt1_q + CNT_W'(1);
            end
        end else if ((state_q == FULL) && bus.rsp_ready_i) begin
            // Drain without refill keeps the last data visible on the response bus.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= EMPTY;
            rsp_s_q    <= '0;
            rsp_c_q    <= 1'b0;
            rsp_id_q   <= 1'b0;
            last_gnt_q <= 1'b1;
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            state_q    <= state_d;
            rsp_s_q    <= rsp_s_d;
            rsp_c_q    <= rsp_c_d;
            rsp_id_q   <= rsp_id_d;
            last_gnt_q <= last_gnt_d;
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end

    assign bus.req0_ready_o = ready0;
    assign bus.req1_ready_o = ready1;
    assign bus.rsp_valid_o  = (state_q == FULL);
    assign bus.rsp_s_o      = rsp_s_q;
    assign bus.rsp_c_o      = rsp_c_q;
    assign bus.rsp_id_o     = rsp_id_q;
    assign bus.gnt_cnt0_o   = gnt_cnt0_q;
    assign bus.gnt_cnt1_o   = gnt_cnt1_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: a constant vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_addsub_arbiter;
    logic clk;
    logic rst_n;

    addsub_arbiter_if #(.DATA_W(4), .CNT_W(8)) bus ();

    addsub_arbiter #(.DATA_W(4), .CNT_W(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [3:0] a0;
        logic [3:0] b0;
        logic       s0;
        logic       v1;
        logic [3:0] a1;
        logic [3:0] b1;
        logic       s1;
        logic       rr;
        logic       e_r0;
        logic       e_r1;
        logic       e_v;
        logic [3:0] e_s;
        logic       e_c;
        logic       e_id;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state: slot contents, last grant and grant tallies as plain integers.
    int m_valid, m_s, m_c, m_id, m_last, m_cnt0, m_cnt1, m_win;
    bit m_rst;

    function automatic vec_t mk(input int v0, a0, b0, s0, v1, a1, b1, s1, rr,
                                input int r0, r1, ev, es, ec, eid);
        vec_t r;
        r.v0 = v0[0]; r.a0 = a0[3:0]; r.b0 = b0[3:0]; r.s0 = s0[0];
        r.v1 = v1[0]; r.a1 = a1[3:0]; r.b1 = b1[3:0]; r.s1 = s1[0];
        r.rr = rr[0];
        r.e_r0 = r0[0]; r.e_r1 = r1[0]; r.e_v = ev[0];
        r.e_s = es[3:0]; r.e_c = ec[0]; r.e_id = eid[0];
        return r;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_valid = 0; m_s = 0; m_c = 0; m_id = 0;
        m_last = 1; m_cnt0 = 0; m_cnt1 = 0; m_win = -1;
        m_rst = 1'b1;
    endtask

    task automatic driveInputs(input int v0, a0, b0, s0, v1, a1, b1, s1, rr);
        bus.req0_valid_i = v0[0]; bus.req0_a_i = a0[3:0]; bus.req0_b_i = b0[3:0]; bus.req0_sel_i = s0[0];
        bus.req1_valid_i = v1[0]; bus.req1_a_i = a1[3:0]; bus.req1_b_i = b1[3:0]; bus.req1_sel_i = s1[0];
        bus.rsp_ready_i  = rr[0];
    endtask

    // One clock cycle: drive, check against the model, clock, advance the model.
    task automatic applyStimulus(input int v0, a0, b0, s0, v1, a1, b1, s1, rr);
        int ta, tb, ts, t;
        driveInputs(v0, a0, b0, s0, v1, a1, b1, s1, rr);
        #1;
        m_win = -1;
        if (!m_rst && (m_valid == 0 || rr != 0)) begin
            if (v0 != 0 && v1 != 0) m_win = (m_last == 0) ? 1 : 0;
            else if (v0 != 0)       m_win = 0;
            else if (v1 != 0)       m_win = 1;
        end
        checkOutput("ready0", bus.req0_ready_o, (m_win == 0) ? 1 : 0);
        checkOutput("ready1", bus.req1_ready_o, (m_win == 1) ? 1 : 0);
        checkOutput("rsp_valid", bus.rsp_valid_o, m_valid);
        checkOutput("rsp_s", bus.rsp_s_o, m_s);
        checkOutput("rsp_c", bus.rsp_c_o, m_c);
        checkOutput("rsp_id", bus.rsp_id_o, m_id);
        checkOutput("gnt_cnt0", bus.gnt_cnt0_o, m_cnt0);
        checkOutput("gnt_cnt1", bus.gnt_cnt1_o, m_cnt1);
        @(posedge clk);
        if (!m_rst) begin
            if (m_win >= 0) begin
                ta = (m_win == 0) ? a0 : a1;
                tb = (m_win == 0) ? b0 : b1;
                ts = (m_win == 0) ? s0 : s1;
                t  = (ts != 0) ? ((ta - tb + 32) % 32) : (ta + tb);
                m_s = t % 16;
                m_c = t / 16;
                m_id = m_win;
                m_valid = 1;
                m_last = m_win;
                if (m_win == 0 && m_cnt0 < 255) m_cnt0++;
                if (m_win == 1 && m_cnt1 < 255) m_cnt1++;
            end else if (m_valid != 0 && rr != 0) begin
                m_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic pulseReset();
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_rst_valid", bus.rsp_valid_o, 0);
        checkOutput("async_rst_s", bus.rsp_s_o, 0);
        checkOutput("async_rst_c", bus.rsp_c_o, 0);
        checkOutput("async_rst_id", bus.rsp_id_o, 0);
        checkOutput("async_rst_cnt0", bus.gnt_cnt0_o, 0);
        checkOutput("async_rst_cnt1", bus.gnt_cnt1_o, 0);
        applyStimulus(1, 1, 1, 0, 1, 2, 2, 0, 1);
        rst_n = 1'b1;
        m_rst = 1'b0;
    endtask

    vec_t vecs[9];
    int   order[4];

    initial begin
        int p0v, p0a, p0b, p0s, p1v, p1a, p1b, p1s, rr;

        vecs[0] = mk(1, 9, 8, 0,  0, 0, 0, 0, 1,  1, 0, 1,  1, 1, 0);
        vecs[1] = mk(0, 0, 0, 0,  1, 3, 5, 1, 1,  0, 1, 1, 14, 1, 1);
        vecs[2] = mk(0, 0, 0, 0,  1, 5, 3, 1, 1,  0, 1, 1,  2, 0, 1);
        vecs[3] = mk(1, 15, 1, 0, 1, 0, 1, 1, 1,  1, 0, 1,  0, 1, 0);
        vecs[4] = mk(1, 7, 7, 0,  1, 0, 1, 1, 1,  0, 1, 1, 15, 1, 1);
        vecs[5] = mk(1, 7, 7, 0,  1, 4, 4, 0, 0,  0, 0, 1, 15, 1, 1);
        vecs[6] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 15, 1, 1);
        vecs[7] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 15, 1, 1);
        vecs[8] = mk(1, 8, 8, 1,  0, 0, 0, 0, 0,  1, 0, 1,  0, 0, 0);
        order = '{0, 1, 0, 1};

        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_valid", bus.rsp_valid_o, 0);
        checkOutput("reset_s", bus.rsp_s_o, 0);
        checkOutput("reset_c", bus.rsp_c_o, 0);
        checkOutput("reset_id", bus.rsp_id_o, 0);
        checkOutput("reset_cnt0", bus.gnt_cnt0_o, 0);
        checkOutput("reset_cnt1", bus.gnt_cnt1_o, 0);
        rst_n = 1'b1;
        m_rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            driveInputs(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].s0,
                        vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].s1, vecs[i].rr);
            #1;
            checkOutput($sformatf("vec%0d_ready0", i), bus.req0_ready_o, vecs[i].e_r0);
            checkOutput($sformatf("vec%0d_ready1", i), bus.req1_ready_o, vecs[i].e_r1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_valid", i), bus.rsp_valid_o, vecs[i].e_v);
            checkOutput($sformatf("vec%0d_s", i), bus.rsp_s_o, vecs[i].e_s);
            checkOutput($sformatf("vec%0d_c", i), bus.rsp_c_o, vecs[i].e_c);
            checkOutput($sformatf("vec%0d_id", i), bus.rsp_id_o, vecs[i].e_id);
            @(negedge clk);
        end
        checkOutput("vec_cnt0", bus.gnt_cnt0_o, 3);
        checkOutput("vec_cnt1", bus.gnt_cnt1_o, 3);

        // Contention straight after reset alternates starting with requester 0.
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 2, 0, 1, 9, 4, 1, 1);
            checkOutput($sformatf("contend%0d_valid", i), bus.rsp_valid_o, 1);
            checkOutput($sformatf("contend%0d_id", i), bus.rsp_id_o, order[i]);
        end
        checkOutput("contend_cnt0", bus.gnt_cnt0_o, 2);
        checkOutput("contend_cnt1", bus.gnt_cnt1_o, 2);

        // Backpressure: slot holds while stalled, then drains and refills in one cycle.
        for (int i = 0; i < 5; i++) applyStimulus(1, 6, 3, 1, 1, 2, 9, 0, 0);
        applyStimulus(1, 6, 3, 1, 1, 2, 9, 0, 1);
        checkOutput("bp_refill_id", bus.rsp_id_o, 0);
        checkOutput("bp_refill_s", bus.rsp_s_o, 3);
        applyStimulus(0, 0, 0, 0, 1, 2, 9, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 2, 9, 0, 0);

        // Reset while full and stalled, then requester 0 wins the first contention.
        pulseReset();
        applyStimulus(1, 4, 4, 0, 1, 1, 1, 0, 1);
        checkOutput("post_rst_id", bus.rsp_id_o, 0);
        checkOutput("post_rst_s", bus.rsp_s_o, 8);

        // Grant counter saturation.
        pulseReset();
        for (int i = 0; i < 300; i++) applyStimulus(1, i % 16, (i / 16) % 16, i % 2, 0, 0, 0, 0, 1);
        checkOutput("sat_cnt0", bus.gnt_cnt0_o, 255);
        checkOutput("sat_cnt1", bus.gnt_cnt1_o, 0);

        // Random traffic; a request holds valid and operands until it is granted.
        pulseReset();
        p0v = 0; p0a = 0; p0b = 0; p0s = 0;
        p1v = 0; p1a = 0; p1b = 0; p1s = 0;
        for (int i = 0; i < 600; i++) begin
            if (p0v == 0 && $urandom_range(0, 3) != 0) begin
                p0v = 1; p0a = $urandom_range(0, 15); p0b = $urandom_range(0, 15); p0s = $urandom_range(0, 1);
            end
            if (p1v == 0 && $urandom_range(0, 3) != 0) begin
                p1v = 1; p1a = $urandom_range(0, 15); p1b = $urandom_range(0, 15); p1s = $urandom_range(0, 1);
            end
            rr = ($urandom_range(0, 3) != 0) ? 1 : 0;
            applyStimulus(p0v, p0a, p0b, p0s, p1v, p1a, p1b, p1s, rr);
            if (m_win == 0) p0v = 0;
            if (m_win == 1) p1v = 0;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4-bit add/subtract datapath between two requesters.
- Each requester presents operands A, B and an op select over a valid/ready handshake.
- The winner's operation is computed and registered into a single-entry response slot, tagged with the requester ID, and drained over a valid/ready response port.
- Sits between issue logic and the shared adder so the adder is never driven by two sources at once.

Parameters:
- DATA_W, 4: operand/sum width; carry/borrow is bit DATA_W of the (DATA_W+1)-bit result.
- CNT_W, 8: width of the per-requester saturating grant counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req0_valid_i  in  1  requester 0 has an operation.
- req0_ready_o  out  1  requester 0 operation accepted this cycle.
- req0_a_i  in  DATA_W  requester 0 operand A.
- req0_b_i  in  DATA_W  requester 0 operand B.
- req0_sel_i  in  1  requester 0 op: 0 = add, 1 = subtract.
- req1_valid_i / req1_ready_o / req1_a_i / req1_b_i / req1_sel_i  same as requester 0, for requester 1.
- rsp_valid_o  out  1  response slot holds a result.
- rsp_ready_i  in  1  consumer takes the result this cycle.
- rsp_s_o  out  DATA_W  result low bits.
- rsp_c_o  out  1  result bit DATA_W (carry on add, borrow on subtract).
- rsp_id_o  out  1  requester that issued the result.
- gnt_cnt0_o  out  CNT_W  number of grants to requester 0, saturating.
- gnt_cnt1_o  out  CNT_W  number of grants to requester 1, saturating.

Behaviour:
- Arithmetic:
  - Zero-extend A and B to DATA_W+1 bits.
  - sel=0: T = A+B. sel=1: T = A-B, modulo 2^(DATA_W+1).
  - rsp_s_o = T[DATA_W-1:0]; rsp_c_o = T[DATA_W].
  - For subtract, rsp_c_o=1 exactly when A<B.
- Slot state machine, two states:
  - EMPTY (rsp_valid_o=0) and FULL (rsp_valid_o=1).
  - accept_ok = EMPTY, or FULL with rsp_ready_i=1 (drain and refill in the same cycle).
- Arbitration (combinational, evaluated each cycle):
  - A register last_gnt holds the most recently granted ID.
  - Only one valid request: that requester is the candidate.
  - Both valid: the requester != last_gnt is the candidate.
  - reqN_ready_o = accept_ok & reqN_valid_i & (candidate == N).
  - At most one ready_o is high per cycle.
  - ready_o does not depend on the other requester's operand data.
- Acceptance, when a ready/valid pair fires:
  - On the next edge, the slot captures {s, c, id}.
  - The state becomes FULL, last_gnt takes the granted ID, and that requester's grant counter increments.
  - Counters saturate at 2^CNT_W-1.
- Latency: result visible on rsp_*_o the cycle after acceptance. Throughput is 1 op/cycle while rsp_ready_i=1.
- Drain without refill (FULL, rsp_ready_i=1, no acceptance): next state is EMPTY and rsp data holds its last value.
- Backpressure: while FULL and rsp_ready_i=0, rsp_s_o, rsp_c_o and rsp_id_o are held stable and both ready_o are 0.
- No request is dropped. A requester keeps valid and operands stable until its ready is seen.
- Reset (asynchronous assert, any time, including mid-transfer):
  - state=EMPTY, rsp_valid_o=0, rsp_s_o=0, rsp_c_o=0, rsp_id_o=0.
  - last_gnt=1, so requester 0 wins the first contention.
  - Both counters = 0.
  - A result in flight is discarded.
  - Release is synchronised by the consumer of the block. No acceptance occurs on a cycle where rst_ni=0.

Test Plan:
- Single add: req0 A=9, B=8, sel=0 -> req0_ready_o=1 that cycle; next cycle rsp_valid_o=1, rsp_s_o=1, rsp_c_o=1, rsp_id_o=0.
- Subtract with borrow: req1 A=3, B=5, sel=1 -> rsp_s_o=14, rsp_c_o=1, rsp_id_o=1. Follow with A=5, B=3 -> rsp_s_o=2, rsp_c_o=0.
- Contention after reset: both valid every cycle, rsp_ready_i=1 -> grant order 0,1,0,1; one result per cycle; gnt_cnt0_o=gnt_cnt1_o=2 after four grants.
- Backpressure: slot FULL and rsp_ready_i=0 for 5 cycles with both requests pending -> both ready_o=0 and rsp_*_o stable. On rsp_ready_i=1, drain and refill happen in the same cycle and the next result appears the following cycle.
- Reset mid-operation: assert rst_ni=0 while FULL and stalled -> rsp_valid_o=0 immediately with all outputs zero. After release, both valid -> requester 0 granted first.
- Counter saturation: 300 back-to-back grants to req0 with CNT_W=8 -> gnt_cnt0_o stops at 255 and gnt_cnt1_o stays 0.
